// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared opcode constants and fetch FSM state encoding
// Used by fetch_unit and program_rom so that both agree on opcode values.
// No ports.

package fetch_unit_pkg;

   localparam logic [3:0] OP_HALT      = 4'd0;
   localparam logic [3:0] OP_SOMA      = 4'd1;
   localparam logic [3:0] OP_SUBTRACAO = 4'd2;
   localparam logic [3:0] OP_MULT      = 4'd3;
   localparam logic [3:0] OP_DIV       = 4'd4;
   localparam logic [3:0] OP_AND       = 4'd5;
   localparam logic [3:0] OP_OR        = 4'd6;
   localparam logic [3:0] OP_XOR       = 4'd7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_OFFER   = 3'd3,
      ST_DONE    = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer, reader side of program_rom
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           begin fetching at address 0 (honoured in IDLE/DONE only)
//   addr_p          ROM address, registered copy of pc
//   out_prom        ROM read data, valid the cycle after addr_p is sampled
//   op_out/op_valid captured opcode offered to the decoder
//   op_ready        decoder accepts op_out when op_valid && op_ready
//   pc              address of the opcode in flight or offered
//   busy            high in ISSUE, CAPTURE and OFFER
//   halted          high in DONE when the sequence ended on HALT_OP

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                 ADDR_W    = 4,
   parameter int                 DATA_W    = 4,
   parameter logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(15),
   parameter logic [DATA_W-1:0]  HALT_OP   = DATA_W'(OP_HALT)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] addr_p,
   input  logic [DATA_W-1:0] out_prom,
   output logic [DATA_W-1:0] op_out,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted
);

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] pc_next;
   logic [DATA_W-1:0] op_out_next;
   logic              op_valid_next;
   logic              halted_next;

   // addr_p is loaded from the same next value as pc so the two never differ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         pc       <= '0;
         addr_p   <= '0;
         op_out   <= '0;
         op_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         addr_p   <= pc_next;
         op_out   <= op_out_next;
         op_valid <= op_valid_next;
         halted   <= halted_next;
      end
   end

   always_comb begin
      state_next    = state;
      pc_next       = pc;
      op_out_next   = op_out;
      op_valid_next = op_valid;
      halted_next   = halted;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               pc_next     = '0;
               halted_next = 1'b0;
               state_next  = ST_ISSUE;
            end
         end
         // The ROM registers addr_p on the edge that ends ISSUE.
         ST_ISSUE: begin
            state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (out_prom == HALT_OP) begin
               halted_next = 1'b1;
               state_next  = ST_DONE;
            end else begin
               op_out_next   = out_prom;
               op_valid_next = 1'b1;
               state_next    = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (op_ready) begin
               op_valid_next = 1'b0;
               if (pc == LAST_ADDR) begin
                  halted_next = 1'b0;
                  state_next  = ST_DONE;
               end else begin
                  pc_next    = pc + ADDR_W'(1);
                  state_next = ST_ISSUE;
               end
            end
         end
         default: begin
            state_next    = ST_IDLE;
            op_valid_next = 1'b0;
         end
      endcase
   end

   assign busy = (state == ST_ISSUE) || (state == ST_CAPTURE) || (state == ST_OFFER);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a ROM model

module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int LAST = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       op_ready;
   logic       op_valid;
   logic       busy;
   logic       halted;
   logic [3:0] addr_p;
   logic [3:0] pc;
   logic [3:0] out_prom;
   logic [3:0] op_out;
   logic [3:0] rom [16];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // program_rom behaviour: registered address, data valid the next cycle
   always @(posedge clk) out_prom <= rom[addr_p];

   fetch_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .addr_p   (addr_p),
      .out_prom (out_prom),
      .op_out   (op_out),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .pc       (pc),
      .busy     (busy),
      .halted   (halted)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One complete fetch run from a start pulse until DONE.
   // Expected opcodes come from walking the ROM contents address by address.
   task automatic run_seq(input int ready_pct, input int stall_op, input int stall_len,
                          input bit start_noise, input bit timed);
      int exp_ops[$];
      int got_ops[$];
      int got_pcs[$];
      int acc_cyc[$];
      int exp_halted;
      int exp_pc;
      int cyc;
      int first_valid;
      int valid_cycles;
      int stall_left;
      int held_op;
      int held_pc;
      bit stalled;
      int n;

      exp_halted = 0;
      exp_pc     = LAST;
      for (int a = 0; a <= LAST; a++) begin
         if (rom[a] == OP_HALT) begin
            exp_halted = 1;
            exp_pc     = a;
            break;
         end
         exp_ops.push_back(int'(rom[a]));
      end

      start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      op_ready = 1'b0;
      cyc      = 0;
      check("start_busy",   busy,     1);
      check("start_pc",     pc,       0);
      check("start_halted", halted,   0);
      check("start_valid",  op_valid, 0);

      first_valid  = -1;
      valid_cycles = 0;
      stalled      = 1'b0;
      stall_left   = stall_len;
      held_op      = 0;
      held_pc      = 0;

      while (busy && cyc < 400) begin
         check("addr_eq_pc", addr_p, pc);
         if (stalled) begin
            check("stall_valid", op_valid, 1);
            check("stall_op",    op_out,   held_op);
            check("stall_pc",    pc,       held_pc);
         end
         if (op_valid) begin
            valid_cycles++;
            if (first_valid < 0) first_valid = cyc;
         end
         if (op_valid && int'(op_out) == stall_op && stall_left > 0) begin
            op_ready = 1'b0;
            stall_left--;
         end else begin
            op_ready = (int'($urandom_range(99)) < ready_pct);
         end
         start   = start_noise ? 1'($urandom_range(1)) : 1'b0;
         stalled = op_valid && !op_ready;
         held_op = int'(op_out);
         held_pc = int'(pc);
         if (op_valid && op_ready) begin
            got_ops.push_back(int'(op_out));
            got_pcs.push_back(int'(pc));
            acc_cyc.push_back(cyc);
         end
         @(posedge clk); #1;
         cyc++;
      end
      start    = 1'b0;
      op_ready = 1'b0;

      check("done_reached", busy,     0);
      check("done_valid",   op_valid, 0);
      check("done_halted",  halted,   exp_halted);
      check("done_pc",      pc,       exp_pc);
      check("done_addr",    addr_p,   exp_pc);
      check("accept_count", got_ops.size(), exp_ops.size());
      n = (got_ops.size() < exp_ops.size()) ? got_ops.size() : exp_ops.size();
      for (int k = 0; k < n; k++) begin
         check("accept_op", got_ops[k], exp_ops[k]);
         check("accept_pc", got_pcs[k], k);
      end

      if (timed) begin
         check("first_valid_cyc", first_valid, (exp_ops.size() > 0) ? 2 : -1);
         check("valid_cycles",    valid_cycles, exp_ops.size());
         for (int k = 0; k < n; k++)
            check("accept_cyc", acc_cyc[k], 2 + 3 * k);
         check("done_cyc", cyc, exp_halted ? 3 * exp_ops.size() + 2 : 3 * exp_ops.size());
      end
   endtask

   task automatic load_basic();
      for (int a = 0; a < 16; a++) rom[a] = 4'($urandom_range(15));
      rom[0] = OP_SOMA;
      rom[1] = OP_SUBTRACAO;
      rom[2] = OP_MULT;
      rom[3] = OP_DIV;
      rom[4] = OP_HALT;
   endtask

   initial begin
      int guard;

      rst      = 1'b1;
      start    = 1'b0;
      op_ready = 1'b0;
      for (int a = 0; a < 16; a++) rom[a] = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid",  op_valid, 0);
      check("rst_busy",   busy,     0);
      check("rst_halted", halted,   0);
      check("rst_pc",     pc,       0);
      check("rst_addr",   addr_p,   0);
      check("rst_op",     op_out,   0);

      // start held together with rst: reset must win
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_start_busy", busy, 0);
      check("rst_start_pc",   pc,   0);
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", busy, 0);

      // HALT at address 4, decoder always ready, exact timing
      load_basic();
      run_seq(100, -1, 0, 1'b0, 1'b1);

      // restart from halted DONE, stall 5 cycles on opcode 2, start noise while busy
      run_seq(100, int'(OP_SUBTRACAO), 5, 1'b1, 1'b0);

      // no HALT anywhere: runs to LAST_ADDR
      for (int a = 0; a < 16; a++) rom[a] = OP_XOR;
      run_seq(100, -1, 0, 1'b0, 1'b1);

      // asynchronous reset in the middle of offering pc=2
      load_basic();
      start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      op_ready = 1'b1;
      guard    = 0;
      while (!(op_valid && pc == 4'd2) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("reach_offer_pc2", (op_valid && pc == 4'd2) ? 1 : 0, 1);
      op_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("async_valid", op_valid, 0);
      check("async_busy",  busy,     0);
      check("async_pc",    pc,       0);
      check("async_addr",  addr_p,   0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_seq(100, -1, 0, 1'b0, 1'b1);

      // randomized programs and decoder back-pressure
      repeat (25) begin
         for (int a = 0; a < 16; a++)
            rom[a] = ($urandom_range(7) == 0) ? OP_HALT : 4'($urandom_range(1, 15));
         run_seq(int'($urandom_range(30, 100)), int'($urandom_range(1, 15)),
                 int'($urandom_range(0, 4)), 1'b1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
